mdu_iter: RTL and testbench

- Iterative multiply/divide unit in the EX stage of the 5-stage pipeline.
- Consumes the forwarded execute-stage operands (ALUIn1E as rs, ALUIn2E as rt) and runs MULT/MULTU/DIV/DIVU over multiple cycles.
- Owns the architectural HI/LO registers; reports busy to the hazard unit, which stalls dependent instructions.

---
 rtl/mdu_iter.sv | 188 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// Owns HI/LO; shift-add multiply and restoring divide, one bit per cycle.
module mdu_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            StartE,
   input  logic [2:0]      MDUOpE,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            CancelE,
   output logic            MDUBusy,
   output logic            MDUDone,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic [XLEN-1:0]     hi_q, hi_d;
   logic [XLEN-1:0]     lo_q, lo_d;
   logic                neg_q, neg_d;
   logic                rneg_q, rneg_d;
   logic                div_q, div_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                is_signed, a_neg, b_neg, b_zero;
   logic [XLEN-1:0]     a_abs, b_abs;
   logic                op_mul, op_div, op_mthi, op_mtlo;
   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       rem_sh;
   logic                div_ge;
   logic [XLEN-1:0]     div_rem;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix;
   logic                last_iter;

   assign is_signed = ~MDUOpE[0];
   assign a_neg     = is_signed & SrcAE[XLEN-1];
   assign b_neg     = is_signed & SrcBE[XLEN-1];
   assign b_zero    = (SrcBE == '0);
   assign a_abs     = a_neg ? -SrcAE : SrcAE;
   assign b_abs     = b_neg ? -SrcBE : SrcBE;

   assign op_mul  = (MDUOpE[2:1] == 2'b00);
   assign op_div  = (MDUOpE[2:1] == 2'b01);
   assign op_mthi = (MDUOpE == 3'b100);
   assign op_mtlo = (MDUOpE == 3'b101);

   // Multiplier sits in the low half and shifts out as the product shifts in.
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, b_q} : '0);

   assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
   assign div_ge  = (rem_sh >= {1'b0, b_q});
   assign div_rem = div_ge ? XLEN'(rem_sh - {1'b0, b_q})
                           : rem_sh[XLEN-1:0];

   assign prod_fix  = neg_q ? -acc_q : acc_q;
   assign quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_fix   = rneg_q ? -acc_q[2*XLEN-1:XLEN]
                             : acc_q[2*XLEN-1:XLEN];
   assign last_iter = (cnt_q == CNT_W'(XLEN-1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      div_d   = div_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (StartE && !CancelE) begin
               unique case (1'b1)
                  op_mul: begin
                     state_d = S_MUL;
                     cnt_d   = '0;
                     acc_d   = {{XLEN{1'b0}}, a_abs};
                     b_d     = b_abs;
                     neg_d   = a_neg ^ b_neg;
                     rneg_d  = 1'b0;
                     div_d   = 1'b0;
                  end
                  op_div: begin
                     state_d = S_DIV;
                     cnt_d   = '0;
                     div_d   = 1'b1;
                     // Zero divisor: raw dividend falls out as remainder.
                     if (b_zero) begin
                        acc_d  = {{XLEN{1'b0}}, SrcAE};
                        b_d    = '0;
                        neg_d  = 1'b0;
                        rneg_d = 1'b0;
                     end else begin
                        acc_d  = {{XLEN{1'b0}}, a_abs};
                        b_d    = b_abs;
                        neg_d  = a_neg ^ b_neg;
                        rneg_d = a_neg;
                     end
                  end
                  op_mthi: hi_d = SrcAE;
                  op_mtlo: lo_d = SrcAE;
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            if (CancelE) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (state_q == S_MUL)
                  acc_d = {mul_sum, acc_q[XLEN-1:1]};
               else
                  acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
               if (last_iter)
                  state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!CancelE) begin
               done_d = 1'b1;
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*XLEN-1:XLEN];
                  lo_d = prod_fix[XLEN-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div_q   <= div_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign MDUBusy = busy_q;
   assign MDUDone = done_q;
   assign HI      = hi_q;
   assign LO      = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: expected {HI,LO} queued at issue,
// popped and compared when MDUDone pulses.
module tb_mdu_iter;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_NOP   = 3'b110;

   logic        clk = 1'b0;
   logic        reset;
   logic        StartE;
   logic [2:0]  MDUOpE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        CancelE;
   logic        MDUBusy;
   logic        MDUDone;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   mdu_iter dut (
      .clk     (clk),
      .reset   (reset),
      .StartE  (StartE),
      .MDUOpE  (MDUOpE),
      .SrcAE   (SrcAE),
      .SrcBE   (SrcBE),
      .CancelE (CancelE),
      .MDUBusy (MDUBusy),
      .MDUDone (MDUDone),
      .HI      (HI),
      .LO      (LO)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      StartE = 1'b1;
      MDUOpE = op;
      SrcAE  = a;
      SrcBE  = b;
      @(negedge clk);
      StartE = 1'b0;
      MDUOpE = OP_NOP;
   endtask

   task automatic wait_done(input string tag, input int exp_busy);
      int busy_n = 0;
      bit seen = 1'b0;
      logic [63:0] e;
      for (int i = 0; i < 64 && !seen; i++) begin
         if (MDUDone) seen = 1'b1;
         else begin
            if (MDUBusy) busy_n++;
            @(negedge clk);
         end
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      chk({tag, "_done"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
         chk({tag, "_busy_at_done"}, 64'(MDUBusy), 64'd0);
         chk({tag, "_hilo"}, {HI, LO}, e);
         @(negedge clk);
         chk({tag, "_done_1cyc"}, 64'(MDUDone), 64'd0);
      end
   endtask

   task automatic run(input string tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp);
      exp_q.push_back(exp);
      issue(op, a, b);
      wait_done(tag, 33);
   endtask

   task automatic no_done(input string tag, input int n);
      int hits = 0;
      repeat (n) begin
         if (MDUDone) hits++;
         @(negedge clk);
      end
      chk(tag, 64'(hits), 64'd0);
   endtask

   initial begin
      reset   = 1'b1;
      StartE  = 1'b0;
      CancelE = 1'b0;
      MDUOpE  = OP_NOP;
      SrcAE   = '0;
      SrcBE   = '0;
      repeat (2) @(negedge clk);
      chk("reset_hilo", {HI, LO}, 64'd0);
      chk("reset_busy", 64'(MDUBusy), 64'd0);
      chk("reset_done", 64'(MDUDone), 64'd0);
      reset = 1'b0;

      run("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003,
          64'hFFFF_FFFF_FFFF_FFFA);
      run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          64'hFFFF_FFFE_0000_0001);
      run("mult_nn", OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFD,
          64'h0000_0000_0000_0015);
      run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
          64'hFFFF_FFFF_FFFF_FFFD);
      run("divu_zero", OP_DIVU, 32'h0000_0064, 32'h0000_0000,
          64'h0000_0064_FFFF_FFFF);
      run("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000,
          64'hFFFF_FFF9_FFFF_FFFF);
      run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          64'h0000_0000_8000_0000);
      run("divu_rem", OP_DIVU, 32'h0000_0064, 32'h0000_0007,
          64'h0000_0002_0000_000E);
      run("div_pos_neg", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE,
          64'h0000_0001_FFFF_FFFD);

      issue(OP_MTHI, 32'h1234_5678, 32'h0);
      chk("mthi_hi", 64'(HI), 64'h1234_5678);
      chk("mthi_busy", 64'(MDUBusy), 64'd0);
      no_done("mthi_no_done", 5);

      exp_q.push_back(64'h0000_0000_0000_0006);
      issue(OP_MULT, 32'd2, 32'd3);
      repeat (4) @(negedge clk);
      StartE = 1'b1;
      MDUOpE = OP_MULT;
      SrcAE  = 32'd7;
      SrcBE  = 32'd7;
      @(negedge clk);
      StartE = 1'b0;
      MDUOpE = OP_NOP;
      wait_done("busy_ignore", 28);

      issue(OP_MTHI, 32'hAAAA_AAAA, 32'h0);
      issue(OP_MTLO, 32'hAAAA_AAAA, 32'h0);
      chk("load_hilo", {HI, LO}, 64'hAAAA_AAAA_AAAA_AAAA);
      issue(OP_DIV, 32'd100, 32'd3);
      repeat (10) @(negedge clk);
      CancelE = 1'b1;
      @(negedge clk);
      CancelE = 1'b0;
      chk("cancel_busy", 64'(MDUBusy), 64'd0);
      no_done("cancel_no_done", 40);
      chk("cancel_hilo", {HI, LO}, 64'hAAAA_AAAA_AAAA_AAAA);

      @(negedge clk);
      StartE  = 1'b1;
      CancelE = 1'b1;
      MDUOpE  = OP_MTLO;
      SrcAE   = 32'h5555_5555;
      @(negedge clk);
      StartE  = 1'b0;
      CancelE = 1'b0;
      MDUOpE  = OP_NOP;
      chk("idle_cancel_lo", 64'(LO), 64'hAAAA_AAAA);
      chk("idle_cancel_busy", 64'(MDUBusy), 64'd0);

      issue(OP_MULT, 32'd1234, 32'd5678);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", 64'(MDUBusy), 64'd0);
      chk("rst_mid_hilo", {HI, LO}, 64'd0);
      no_done("rst_mid_no_done", 40);
      run("multu_after_rst", OP_MULTU, 32'd3, 32'd5,
          64'h0000_0000_0000_000F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
